// File: rtl/rtmq_cfg_uart_sender.sv
// RTMQ configuration frame sender: buffers {f_cfg, cfg_ins} entries in a small
// FIFO and shifts each one out as NB = (W_REG+8)/8 back-to-back 8N1-style bytes.
// The flag byte goes first, then the instruction word MSB first; each byte is
// sent LSB first.
//
// Write handshake: an entry is taken on a clk edge where wr_en && wr_rdy.
// wr_rdy depends only on the FIFO count, never on wr_en, and a write on the
// same edge as a pop from a full FIFO is refused.
//
// uart_tx and sent are registered. They lag the FSM state by one cycle, so a
// write into an empty, idle sender gives a pop on the next edge and the start
// bit falls on the edge after that.
module rtmq_cfg_uart_sender #(
  parameter int W_REG      = 32,
  parameter int BAUD_DIV   = 868,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W_REG-1:0] cfg_ins,
  input  logic             f_cfg,
  input  logic             wr_en,
  output logic             wr_rdy,
  output logic             uart_tx,
  output logic             busy,
  output logic             sent
);

  localparam int W_FRM    = W_REG + 8;
  localparam int NB       = W_FRM / 8;
  localparam int AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int STOP_LEN = STOP_BITS * BAUD_DIV;
  localparam int CW       = $clog2(STOP_LEN + 1);
  localparam int BW       = $clog2(NB + 1);

  localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_LEN - 1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(NB - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // FIFO storage and pointers
  logic [W_REG:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic            push, pop, empty, full;

  // Transmit FSM state
  state_t          state_q, state_d;
  logic [CW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [BW-1:0]   byte_q, byte_d;
  logic [W_FRM-1:0] frame_q, frame_d;
  logic            tx_q, tx_d;
  logic            done_q, done_d;
  logic            sent_q;
  logic [7:0]      cur_byte;

  assign full     = (cnt_q == FULL_CNT);
  assign empty    = (cnt_q == '0);
  assign wr_rdy   = !full;
  assign push     = wr_en && !full;
  assign cur_byte = frame_q[W_FRM-1 -: 8];
  assign uart_tx  = tx_q;
  assign sent     = sent_q;
  assign busy     = (state_q != IDLE) || !empty;

  // FIFO entry write; storage needs no reset since the count gates reads
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {f_cfg, cfg_ins};
  end

  // FIFO pointer and occupancy update
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    cnt_d    = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Next state, counters and the line value for the current state
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    frame_d = frame_q;
    tx_d    = 1'b1;
    done_d  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          frame_d = {7'b0, mem_q[rd_ptr_q]};
          byte_d  = '0;
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (baud_q == BIT_LAST) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        tx_d = cur_byte[bit_q];
        if (baud_q == BIT_LAST) begin
          baud_d = '0;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_q == STOP_LAST) begin
          baud_d = '0;
          if (byte_q < BYTE_LAST) begin
            byte_d  = byte_q + 1'b1;
            frame_d = {frame_q[W_FRM-9:0], 8'h00};
            state_d = START;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset abandons any frame and forces the line high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      frame_q  <= '0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
      sent_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      frame_q  <= frame_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
      sent_q   <= done_q;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: doc/rtmq_cfg_uart_sender.md
Name: rtmq_cfg_uart_sender

Overview:
- Host/master-side counterpart of the RTMQ UART configuration receiver.
- Accepts configuration instruction words plus an override flag, and buffers them in a small FIFO.
- Serializes each entry as one configuration frame of (W_REG+8) bits, sent as 8N1-style UART bytes.
- Used on a controller board driving a slave RTMQ core, or as loopback stimulus for the receiver.

Parameters:
- W_REG, 32, instruction width; must be a multiple of 8.
- BAUD_DIV, 868, clock cycles per UART bit (F_CLK/F_BDR); must be >= 2.
- STOP_BITS, 1, stop bits per byte; 1 or 2.
- FIFO_DEPTH, 4, frame FIFO entries; power of 2, >= 2.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- cfg_ins, input, W_REG, instruction word to send.
- f_cfg, input, 1, configuration override flag to send.
- wr_en, input, 1, write strobe; entry accepted when wr_en && wr_rdy at a clk edge.
- wr_rdy, output, 1, FIFO not full (combinational from FIFO count).
- uart_tx, output, 1, UART Tx line, idle high.
- busy, output, 1, high while FSM is not IDLE or FIFO is non-empty.
- sent, output, 1, one-cycle pulse when the last stop bit of a frame completes.

Behaviour:
- Reset (async, any state):
  - uart_tx=1, busy=0, sent=0, wr_rdy=1.
  - FIFO emptied; FSM to IDLE; baud/bit/byte counters cleared.
  - A frame in flight is abandoned; the line returns high immediately.
- Frame format, NB = (W_REG+8)/8 bytes:
  - Byte 0 = {7'b0, f_cfg}.
  - Bytes 1..NB-1 = cfg_ins, most-significant byte first.
  - Each byte: start bit 0, 8 data bits LSB first, STOP_BITS stop bits of 1.
  - Each bit held for exactly BAUD_DIV cycles.
  - Bytes within a frame are back-to-back with no gap.
- FIFO: stores {f_cfg, cfg_ins}.
  - Write when wr_en && !full; a write while full is dropped, with no state change.
  - Simultaneous write and pop when full: the write is still refused (wr_rdy=0 that cycle).
  - Simultaneous write and pop when not full: both occur; count unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: uart_tx=1. If FIFO non-empty, pop into frame shift register (W_REG+8 bits), set byte counter=0, go to START.
  - START: uart_tx=0 for BAUD_DIV cycles, then go to DATA with bit counter=0.
  - DATA: uart_tx = current byte bit[bit counter]. After 8 bits of BAUD_DIV cycles each, go to STOP.
  - STOP: uart_tx=1 for STOP_BITS*BAUD_DIV cycles.
    - Then, if byte counter < NB-1: increment it and go to START.
    - Otherwise: pulse sent, go to IDLE.
- Latency:
  - A write into an empty FIFO with FSM in IDLE at edge N gives a pop at edge N+1.
  - uart_tx falls at edge N+2.
  - Consecutive frames are separated by exactly one extra idle-high cycle (the IDLE state).
- Frame length:
  - Low edge of start bit to end of last stop bit = NB*(9+STOP_BITS)*BAUD_DIV cycles.
  - sent is asserted in the cycle following that.
- busy:
  - Deasserts in the cycle the FSM enters IDLE with the FIFO empty.
  - May remain high continuously across back-to-back frames.
- Inputs are sampled only on an accepted write; changes to cfg_ins/f_cfg afterwards do not affect a queued frame.

Test Plan:
- Single frame. W_REG=32, BAUD_DIV=4, STOP_BITS=1. Write cfg_ins=0xDEADBEEF, f_cfg=1 -> line decodes bytes 0x01, 0xDE, 0xAD, 0xBE, 0xEF. Each bit is 4 cycles. uart_tx falls 2 cycles after the write. sent pulses once, 200 cycles after the falling edge.
- Fill FIFO. Write 5 entries back-to-back (0x00000001..0x00000005, f_cfg=0) with FIFO_DEPTH=4 -> wr_rdy drops once 4 entries are queued. Depending on pop timing, exactly 4 or 5 frames are sent, matching the accepted writes. No corruption; busy stays high until the final sent.
- Back-to-back frames. Queue 2 frames -> exactly 1 idle-high cycle between the last stop bit of frame 1 and the start bit of frame 2. sent pulses twice.
- Reset mid-frame. Assert rst during byte 2's DATA state -> uart_tx=1 asynchronously and FIFO empty. After release, with no writes, uart_tx stays high and sent never pulses.
- Two stop bits. STOP_BITS=2, BAUD_DIV=3, write 0x12345678, f_cfg=0 -> bytes 0x00, 0x12, 0x34, 0x56, 0x78, each stop 6 cycles high. Frame = 5*11*3 = 165 cycles.
- Input stability. Change cfg_ins on the cycle after the write -> the transmitted frame carries the originally accepted value.
